boiler_stack_ctrl: RTL and testbench

//  Game-state engine for a 4-boiler colour-sort puzzle; sits directly upstream
//  of the per-boiler sprite renderers. Holds 4 layers x 3-bit colour per boiler,

---
 rtl/boiler_stack_ctrl_if.sv | 24 ++
 rtl/boiler_stack_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_boiler_stack_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boiler_stack_ctrl_if.sv
// Button inputs and renderer-facing outputs of the boiler puzzle engine.
// The slave side is the engine; the master side is whatever drives the buttons.
interface boiler_stack_ctrl_if;
    logic        btn_left;
    logic        btn_right;
    logic        btn_sel;
    logic        btn_restart;
    logic [47:0] colours_o;
    logic [3:0]  selected_o;
    logic [3:0]  picked_o;
    logic        busy_o;
    logic        solved_o;
    logic [7:0]  moves_o;

    modport slave (
        input  btn_left, btn_right, btn_sel, btn_restart,
        output colours_o, selected_o, picked_o, busy_o, solved_o, moves_o
    );

    modport master (
        output btn_left, btn_right, btn_sel, btn_restart,
        input  colours_o, selected_o, picked_o, busy_o, solved_o, moves_o
    );
endinterface

// File: rtl/boiler_stack_ctrl.sv
// Game-state engine for a 4-boiler colour-sort puzzle: cursor, pick/pour moves
// with a timed layer-by-layer pour, move counter and solved detection.
module boiler_stack_ctrl #(
    parameter int unsigned POUR_TICKS  = 2_500_000,
    parameter logic [47:0] INIT_LAYOUT = 48'h000_68B_45A_2D1
) (
    input  logic              CLOCK,
    input  logic              rst_n,
    boiler_stack_ctrl_if.slave bus
);
    localparam int unsigned   CW = (POUR_TICKS > 1) ? $clog2(POUR_TICKS) : 1;
    localparam logic [CW-1:0] TC = CW'(POUR_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PICKED = 2'd1, S_POUR = 2'd2} state_t;

    function automatic logic [11:0] get_boiler(input logic [47:0] c, input logic [1:0] b);
        case (b)
            2'd0:    get_boiler = c[11:0];
            2'd1:    get_boiler = c[23:12];
            2'd2:    get_boiler = c[35:24];
            2'd3:    get_boiler = c[47:36];
            default: get_boiler = 12'd0;
        endcase
    endfunction

    function automatic logic [2:0] layer_count(input logic [11:0] s);
        layer_count = 3'd0;
        for (int l = 0; l < 4; l++) begin
            if (s[l*3 +: 3] != 3'd0) layer_count = layer_count + 3'd1;
            else                     layer_count = layer_count;
        end
    endfunction

    // Colour at depth d below the top (d=0 is the top layer); 0 if absent.
    function automatic logic [2:0] layer_from_top(input logic [11:0] s, input logic [2:0] d);
        logic [2:0] n;
        n = layer_count(s);
        if (n <= d) return 3'd0;
        else begin
            case (3'(n - d))
                3'd1:    return s[2:0];
                3'd2:    return s[5:3];
                3'd3:    return s[8:6];
                3'd4:    return s[11:9];
                default: return 3'd0;
            endcase
        end
    endfunction

    function automatic logic is_solved(input logic [47:0] c);
        logic [11:0] s;
        is_solved = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s = c[b*12 +: 12];
            if ((s[11:9] != s[2:0]) || (s[8:6] != s[2:0]) || (s[5:3] != s[2:0]))
                is_solved = 1'b0;
            else
                is_solved = is_solved;
        end
    endfunction

    state_t        r_state;
    logic [47:0]   r_colours;
    logic [1:0]    r_cursor;
    logic [3:0]    r_selected;
    logic [1:0]    r_src;
    logic [1:0]    r_dst;
    logic [3:0]    r_picked;
    logic          r_busy;
    logic          r_solved;
    logic [7:0]    r_moves;
    logic [CW-1:0] r_cnt;

    logic [11:0] w_src_s, w_dst_s, w_cur_s;
    logic [2:0]  w_src_cnt, w_dst_cnt, w_cur_cnt;
    logic [2:0]  w_src_top, w_cur_top;
    logic [1:0]  w_cur_nxt;
    logic        w_legal;
    logic        w_continue;
    logic [47:0] w_after;

    assign w_src_s   = get_boiler(r_colours, r_src);
    assign w_dst_s   = get_boiler(r_colours, r_dst);
    assign w_cur_s   = get_boiler(r_colours, r_cursor);
    assign w_src_cnt = layer_count(w_src_s);
    assign w_dst_cnt = layer_count(w_dst_s);
    assign w_cur_cnt = layer_count(w_cur_s);
    assign w_src_top = layer_from_top(w_src_s, 3'd0);
    assign w_cur_top = layer_from_top(w_cur_s, 3'd0);
    assign w_legal   = (w_cur_cnt < 3'd4) && ((w_cur_cnt == 3'd0) || (w_cur_top == w_src_top));

    // Cursor step; simultaneous left and right cancel out.
    always_comb begin
        w_cur_nxt = r_cursor;
        if (bus.btn_left && !bus.btn_right)      w_cur_nxt = r_cursor - 2'd1;
        else if (bus.btn_right && !bus.btn_left) w_cur_nxt = r_cursor + 2'd1;
        else                                     w_cur_nxt = r_cursor;
    end

    // One-layer transfer src top -> dst next free slot, and whether another follows.
    always_comb begin
        w_after    = r_colours;
        w_continue = 1'b0;
        if ((w_src_cnt != 3'd0) && (w_dst_cnt < 3'd4)) begin
            for (int b = 0; b < 4; b++) begin
                for (int l = 0; l < 4; l++) begin
                    if ((b == int'(r_src)) && (l == int'(w_src_cnt) - 1))
                        w_after[b*12 + l*3 +: 3] = 3'd0;
                    else if ((b == int'(r_dst)) && (l == int'(w_dst_cnt)))
                        w_after[b*12 + l*3 +: 3] = w_src_top;
                    else
                        w_after[b*12 + l*3 +: 3] = r_colours[b*12 + l*3 +: 3];
                end
            end
            w_continue = (w_src_cnt > 3'd1) && (w_dst_cnt < 3'd3) &&
                         (layer_from_top(w_src_s, 3'd1) == w_src_top);
        end else begin
            w_after    = r_colours;
            w_continue = 1'b0;
        end
    end

    // Game FSM with all outputs held in registers.
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_colours  <= INIT_LAYOUT;
            r_cursor   <= 2'd0;
            r_selected <= 4'b0001;
            r_src      <= 2'd0;
            r_dst      <= 2'd0;
            r_picked   <= 4'b0000;
            r_busy     <= 1'b0;
            r_solved   <= 1'b0;
            r_moves    <= 8'd0;
            r_cnt      <= '0;
        end else begin
            if (r_state == S_IDLE) r_solved <= is_solved(r_colours);
            else                   r_solved <= r_solved;

            if (bus.btn_restart) begin
                r_state   <= S_IDLE;
                r_colours <= INIT_LAYOUT;
                r_picked  <= 4'b0000;
                r_busy    <= 1'b0;
                r_moves   <= 8'd0;
                r_cnt     <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cursor   <= w_cur_nxt;
                        r_selected <= 4'b0001 << w_cur_nxt;
                        if (bus.btn_sel && (w_cur_cnt != 3'd0)) begin
                            r_state  <= S_PICKED;
                            r_src    <= r_cursor;
                            r_picked <= 4'b0001 << r_cursor;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_PICKED: begin
                        r_cursor   <= w_cur_nxt;
                        r_selected <= 4'b0001 << w_cur_nxt;
                        if (bus.btn_sel) begin
                            if ((r_cursor != r_src) && w_legal) begin
                                r_state <= S_POUR;
                                r_dst   <= r_cursor;
                                r_busy  <= 1'b1;
                                r_cnt   <= '0;
                                r_moves <= (r_moves == 8'd255) ? r_moves : r_moves + 8'd1;
                            end else begin
                                r_state  <= S_IDLE;
                                r_picked <= 4'b0000;
                            end
                        end else begin
                            r_state <= S_PICKED;
                        end
                    end
                    S_POUR: begin
                        if (r_cnt == TC) begin
                            r_cnt     <= '0;
                            r_colours <= w_after;
                            if (!w_continue) begin
                                r_state  <= S_IDLE;
                                r_busy   <= 1'b0;
                                r_picked <= 4'b0000;
                            end else begin
                                r_state <= S_POUR;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_picked <= 4'b0000;
                        r_busy   <= 1'b0;
                        r_cnt    <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.colours_o  = r_colours;
    assign bus.selected_o = r_selected;
    assign bus.picked_o   = r_picked;
    assign bus.busy_o     = r_busy;
    assign bus.solved_o   = r_solved;
    assign bus.moves_o    = r_moves;
endmodule

// File: tb/tb_boiler_stack_ctrl.sv
// Self-checking bench for boiler_stack_ctrl: directed puzzle scenarios plus
// random button traffic, compared cycle by cycle against a behavioural model.
module tb_boiler_stack_ctrl;
    localparam int          T    = 4;
    localparam logic [47:0] INIT = 48'h000_68B_45A_2D1;

    logic CLOCK = 1'b0;
    logic rst_n = 1'b0;

    boiler_stack_ctrl_if bif();

    boiler_stack_ctrl #(.POUR_TICKS(T), .INIT_LAYOUT(INIT)) dut (
        .CLOCK(CLOCK),
        .rst_n(rst_n),
        .bus  (bif.slave)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: each boiler is a bottom-up list of colours; a pour is planned in full
    // when accepted (how many layers, one every T cycles).
    int m_col [4][4];
    int m_cur, m_state, m_src, m_dst, m_wait, m_left, m_moves;
    bit m_solved;

    function automatic void m_load();
        logic [47:0] v;
        v = INIT;
        for (int b = 0; b < 4; b++)
            for (int l = 0; l < 4; l++)
                m_col[b][l] = int'(v[b*12 + l*3 +: 3]);
    endfunction

    function automatic int m_count(input int b);
        int n = 0;
        for (int l = 0; l < 4; l++) if (m_col[b][l] != 0) n++;
        return n;
    endfunction

    function automatic int m_top(input int b);
        int n = m_count(b);
        return (n == 0) ? 0 : m_col[b][n-1];
    endfunction

    function automatic int m_run(input int b);
        int n = m_count(b);
        int r = 0;
        for (int l = n - 1; l >= 0; l--) begin
            if (m_col[b][l] != m_col[b][n-1]) break;
            r++;
        end
        return r;
    endfunction

    function automatic bit m_is_solved();
        for (int b = 0; b < 4; b++)
            for (int l = 1; l < 4; l++)
                if (m_col[b][l] != m_col[b][0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [47:0] m_pack();
        logic [47:0] v = '0;
        for (int b = 0; b < 4; b++)
            for (int l = 0; l < 4; l++)
                v[b*12 + l*3 +: 3] = 3'(m_col[b][l]);
        return v;
    endfunction

    task automatic m_step(input bit l, input bit r, input bit s, input bit rs);
        bit ns   = m_solved;
        int old  = m_cur;
        int ncur = m_cur;
        int sc, dc, room;
        if (m_state == 0) ns = m_is_solved();
        if (l && !r)      ncur = (m_cur + 3) % 4;
        else if (r && !l) ncur = (m_cur + 1) % 4;
        if (rs) begin
            m_load();
            m_state = 0; m_moves = 0; m_left = 0;
        end else if (m_state == 0) begin
            m_cur = ncur;
            if (s && m_count(old) > 0) begin m_state = 1; m_src = old; end
        end else if (m_state == 1) begin
            m_cur = ncur;
            if (s) begin
                if (old != m_src && m_count(old) < 4 &&
                    (m_count(old) == 0 || m_top(old) == m_top(m_src))) begin
                    m_dst   = old;
                    room    = 4 - m_count(old);
                    m_left  = (m_run(m_src) < room) ? m_run(m_src) : room;
                    m_wait  = T;
                    m_state = 2;
                    m_moves = (m_moves < 255) ? m_moves + 1 : 255;
                end else begin
                    m_state = 0;
                end
            end
        end else begin
            m_wait--;
            if (m_wait == 0) begin
                sc = m_count(m_src);
                dc = m_count(m_dst);
                m_col[m_dst][dc]   = m_col[m_src][sc-1];
                m_col[m_src][sc-1] = 0;
                m_left--;
                if (m_left == 0) m_state = 0;
                else             m_wait  = T;
            end
        end
        m_solved = ns;
    endtask

    task automatic compare_all();
        check_eq("colours",  bif.colours_o,  m_pack());
        check_eq("selected", bif.selected_o, 48'(4'b0001 << m_cur));
        check_eq("picked",   bif.picked_o,   (m_state != 0) ? 48'(4'b0001 << m_src) : 48'd0);
        check_eq("busy",     bif.busy_o,     48'(m_state == 2));
        check_eq("solved",   bif.solved_o,   48'(m_solved));
        check_eq("moves",    bif.moves_o,    48'(m_moves));
    endtask

    task automatic step(input bit l, input bit r, input bit s, input bit rs);
        @(negedge CLOCK);
        bif.btn_left = l; bif.btn_right = r; bif.btn_sel = s; bif.btn_restart = rs;
        m_step(l, r, s, rs);
        @(posedge CLOCK);
        #1;
        compare_all();
    endtask

    task automatic goto(input int b);
        for (int i = 0; i < 4 && m_cur != b; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pour(input int a, input int b);
        goto(a);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        goto(b);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 40 && m_state != 0; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int seq_src [10] = '{0, 2, 1, 1, 0, 2, 2, 1, 0, 0};
    int seq_dst [10] = '{3, 0, 2, 3, 1, 0, 3, 2, 1, 3};

    initial begin
        bif.btn_left = 1'b0; bif.btn_right = 1'b0; bif.btn_sel = 1'b0; bif.btn_restart = 1'b0;
        m_load();
        m_cur = 0; m_state = 0; m_src = 0; m_dst = 0; m_wait = 0; m_left = 0;
        m_moves = 0; m_solved = 1'b0;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        rst_n = 1'b1;
        #1;
        check_eq("rst_colours",  bif.colours_o,  48'h000_68B_45A_2D1);
        check_eq("rst_selected", bif.selected_o, 48'h1);
        check_eq("rst_picked",   bif.picked_o,   48'h0);
        check_eq("rst_busy",     bif.busy_o,     48'h0);
        check_eq("rst_moves",    bif.moves_o,    48'h0);
        check_eq("rst_solved",   bif.solved_o,   48'h0);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("cur_left_wrap", bif.selected_o, 48'b1000);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("cur_right2", bif.selected_o, 48'b0010);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("cur_both", bif.selected_o, 48'b0010);

        // Single-layer pour 0 -> 3 with exact timing.
        goto(0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("pick0", bif.picked_o, 48'b0001);
        goto(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("pour_busy", bif.busy_o, 48'h1);
        check_eq("pour_moves", bif.moves_o, 48'h1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("pour_wait", bif.colours_o, 48'h000_68B_45A_2D1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("pour_b0", bif.colours_o[11:0], 48'h0D1);
        check_eq("pour_b3", bif.colours_o[47:36], 48'h001);
        check_eq("pour_done_busy", bif.busy_o, 48'h0);
        check_eq("pour_done_picked", bif.picked_o, 48'h0);

        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("restart_colours", bif.colours_o, 48'h000_68B_45A_2D1);
        check_eq("restart_moves", bif.moves_o, 48'h0);

        // Illegal pour onto full boiler, then select on empty boiler.
        pour(0, 1);
        check_eq("illegal_colours", bif.colours_o, 48'h000_68B_45A_2D1);
        check_eq("illegal_moves", bif.moves_o, 48'h0);
        goto(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("empty_sel", bif.picked_o, 48'h0);

        // Restart in the middle of a pour.
        goto(0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        goto(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("midpour_colours", bif.colours_o, 48'h000_68B_45A_2D1);
        check_eq("midpour_busy", bif.busy_o, 48'h0);
        check_eq("midpour_moves", bif.moves_o, 48'h0);
        pour(0, 3);

        // Full solution of the initial layout, with several multi-layer pours.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) pour(seq_src[i], seq_dst[i]);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("solved_layout", bif.colours_o, 48'h249_6DB_492_000);
        check_eq("solved_flag", bif.solved_o, 48'h1);
        check_eq("solved_moves", bif.moves_o, 48'd10);
        goto(1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Random button traffic.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 149) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
